oitf_tagq: RTL and testbench

- Parametrised successor to the core's outstanding-instruction-tracking FIFO.
- Tracks long-latency instructions (mul/div/load) between decode/dispatch and the long-pipe writeback units.
- Allocates a tag per long instruction and accepts out-of-order completion by tag; retires entries in order from a circular queue.
- Raises RAW/WAW hazard stalls against all in-flight, not-yet-completed destinations.

---
 rtl/oitf_tagq_if.sv | 39 +++
 rtl/oitf_tagq.sv | 97 +++++++++
 tb/tb_oitf_tagq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/oitf_tagq_if.sv
// Dispatch/commit/status bundle for oitf_tagq; master drives dispatch and
// commit requests, slave (the tracker) returns ready, tag, hazard and occupancy.
interface oitf_tagq_if #(
  parameter int DEPTH    = 4,
  parameter int REGIDX_W = 5
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                disp_vld;
  logic                disp_rdy;
  logic                disp_long;
  logic                disp_rdwen;
  logic [REGIDX_W-1:0] disp_rdidx;
  logic                disp_rs1en;
  logic [REGIDX_W-1:0] disp_rs1idx;
  logic                disp_rs2en;
  logic [REGIDX_W-1:0] disp_rs2idx;
  logic [PTR_W-1:0]    disp_tag;
  logic                disp_hazard;
  logic                cmt_vld;
  logic [PTR_W-1:0]    cmt_tag;
  logic                oitf_empty;
  logic                oitf_full;
  logic [PTR_W:0]      oitf_cnt;

  modport master (
    output disp_vld, disp_long, disp_rdwen, disp_rdidx,
           disp_rs1en, disp_rs1idx, disp_rs2en, disp_rs2idx,
           cmt_vld, cmt_tag,
    input  disp_rdy, disp_tag, disp_hazard, oitf_empty, oitf_full, oitf_cnt
  );

  modport slave (
    input  disp_vld, disp_long, disp_rdwen, disp_rdidx,
           disp_rs1en, disp_rs1idx, disp_rs2en, disp_rs2idx,
           cmt_vld, cmt_tag,
    output disp_rdy, disp_tag, disp_hazard, oitf_empty, oitf_full, oitf_cnt
  );
endinterface

// File: rtl/oitf_tagq.sv
// Outstanding-instruction tag queue: in-order alloc/retire, out-of-order completion by tag.
// Optional OITF_CMT_BYPASS_EN lets a same-cycle completion clear hazards and free a full slot.
module oitf_tagq #(
  parameter int DEPTH    = 4,
  parameter int REGIDX_W = 5
) (
  input logic        i_clk,
  input logic        i_rst,
  oitf_tagq_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]    r_vld;
  logic [DEPTH-1:0]    r_done;
  logic [DEPTH-1:0]    r_rdwen;
  logic [REGIDX_W-1:0] r_rdidx [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [PTR_W:0]      r_cnt;

  logic [DEPTH-1:0] w_live;
  logic             w_hazard;
  logic             w_full;
  logic             w_pop;
  logic             w_rdy;
  logic             w_alloc;
  logic             w_cmtHit;

  always_comb begin
    w_live   = '0;
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_live[i] = r_vld[i] & ~r_done[i] & r_rdwen[i];
`ifdef OITF_CMT_BYPASS_EN
      if (bus.cmt_vld && (bus.cmt_tag == PTR_W'(i)))
        w_live[i] = 1'b0;
`endif
      if (w_live[i] &&
          ((bus.disp_rs1en && (r_rdidx[i] == bus.disp_rs1idx)) ||
           (bus.disp_rs2en && (r_rdidx[i] == bus.disp_rs2idx)) ||
           (bus.disp_rdwen && (r_rdidx[i] == bus.disp_rdidx))))
        w_hazard = 1'b1;
    end
  end

  assign w_full   = (r_cnt == (PTR_W+1)'(DEPTH));
  assign w_pop    = r_vld[r_rptr] & (r_done[r_rptr] | (bus.cmt_vld & (bus.cmt_tag == r_rptr)));
  assign w_cmtHit = bus.cmt_vld & r_vld[bus.cmt_tag] & ~r_done[bus.cmt_tag];

`ifdef OITF_CMT_BYPASS_EN
  assign w_rdy = ~w_hazard & ~(bus.disp_long & w_full & ~w_pop);
`else
  assign w_rdy = ~w_hazard & ~(bus.disp_long & w_full);
`endif

  assign w_alloc = bus.disp_vld & w_rdy & bus.disp_long;

  // Alloc is written last so a same-cycle pop of the slot it reuses loses.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_vld   <= '0;
      r_done  <= '0;
      r_rdwen <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_rdidx[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_cmtHit)
        r_done[bus.cmt_tag] <= 1'b1;
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (w_alloc) begin
        r_vld[r_wptr]   <= 1'b1;
        r_done[r_wptr]  <= 1'b0;
        r_rdwen[r_wptr] <= bus.disp_rdwen;
        r_rdidx[r_wptr] <= bus.disp_rdidx;
        r_wptr          <= r_wptr + 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.disp_rdy    = w_rdy;
  assign bus.disp_tag    = r_wptr;
  assign bus.disp_hazard = w_hazard;
  assign bus.oitf_empty  = (r_cnt == '0);
  assign bus.oitf_full   = w_full;
  assign bus.oitf_cnt    = r_cnt;
endmodule

// File: tb/tb_oitf_tagq.sv
// Bench for oitf_tagq: directed literal checks plus random traffic against a
// queue-based model of in-flight instructions, compared every cycle.
module tb_oitf_tagq;
  localparam int DEPTH    = 4;
  localparam int REGIDX_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oitf_tagq_if #(.DEPTH(DEPTH), .REGIDX_W(REGIDX_W)) bus ();

  oitf_tagq #(.DEPTH(DEPTH), .REGIDX_W(REGIDX_W)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    int tag;
    bit rdwen;
    int rdidx;
    bit done;
  } ent_t;

  ent_t q[$];
  int   nextTag = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit modelHazard();
    bit h = 1'b0;
    foreach (q[i]) begin
      if (!q[i].done && q[i].rdwen) begin
`ifdef OITF_CMT_BYPASS_EN
        if (bus.cmt_vld && int'(bus.cmt_tag) == q[i].tag) continue;
`endif
        if ((bus.disp_rs1en && q[i].rdidx == int'(bus.disp_rs1idx)) ||
            (bus.disp_rs2en && q[i].rdidx == int'(bus.disp_rs2idx)) ||
            (bus.disp_rdwen && q[i].rdidx == int'(bus.disp_rdidx)))
          h = 1'b1;
      end
    end
    return h;
  endfunction

  function automatic bit modelPop();
    if (q.size() == 0) return 1'b0;
    return q[0].done || (bus.cmt_vld && int'(bus.cmt_tag) == q[0].tag);
  endfunction

  function automatic bit modelRdy();
    bit blockFull = bus.disp_long && (q.size() == DEPTH);
`ifdef OITF_CMT_BYPASS_EN
    blockFull = blockFull && !modelPop();
`endif
    return !modelHazard() && !blockFull;
  endfunction

  task automatic modelStep();
    bit   alloc = bus.disp_vld && modelRdy() && bus.disp_long;
    bit   pop   = modelPop();
    ent_t e;
    if (bus.cmt_vld)
      foreach (q[i])
        if (q[i].tag == int'(bus.cmt_tag)) q[i].done = 1'b1;
    if (pop) void'(q.pop_front());
    if (alloc) begin
      e.tag   = nextTag;
      e.rdwen = bus.disp_rdwen;
      e.rdidx = int'(bus.disp_rdidx);
      e.done  = 1'b0;
      q.push_back(e);
      nextTag = (nextTag + 1) % DEPTH;
    end
  endtask

  // Per-cycle compare at the falling edge, model advance at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        nextTag = 0;
      end
      checkOutput("disp_rdy",    int'(bus.disp_rdy),    int'(modelRdy()));
      checkOutput("disp_hazard", int'(bus.disp_hazard), int'(modelHazard()));
      checkOutput("disp_tag",    int'(bus.disp_tag),    nextTag);
      checkOutput("oitf_cnt",    int'(bus.oitf_cnt),    q.size());
      checkOutput("oitf_empty",  int'(bus.oitf_empty),  int'(q.size() == 0));
      checkOutput("oitf_full",   int'(bus.oitf_full),   int'(q.size() == DEPTH));
      @(posedge clk);
      if (rst_n) modelStep();
    end
  end

  task automatic applyStimulus(input int vld, input int lng, input int rdwen, input int rd,
                               input int rs1en, input int rs1, input int rs2en, input int rs2,
                               input int cmtv, input int cmtt);
    @(posedge clk);
    #1;
    bus.disp_vld    = vld[0];
    bus.disp_long   = lng[0];
    bus.disp_rdwen  = rdwen[0];
    bus.disp_rdidx  = REGIDX_W'(rd);
    bus.disp_rs1en  = rs1en[0];
    bus.disp_rs1idx = REGIDX_W'(rs1);
    bus.disp_rs2en  = rs2en[0];
    bus.disp_rs2idx = REGIDX_W'(rs2);
    bus.cmt_vld     = cmtv[0];
    bus.cmt_tag     = 2'(cmtt);
  endtask

  initial begin
    int ct;
    bus.disp_vld = 0; bus.disp_long = 0; bus.disp_rdwen = 0; bus.disp_rdidx = '0;
    bus.disp_rs1en = 0; bus.disp_rs1idx = '0; bus.disp_rs2en = 0; bus.disp_rs2idx = '0;
    bus.cmt_vld = 0; bus.cmt_tag = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_tag",   int'(bus.disp_tag),    0);
    checkOutput("rst_rdy",   int'(bus.disp_rdy),    1);
    checkOutput("rst_empty", int'(bus.oitf_empty),  1);
    checkOutput("rst_full",  int'(bus.oitf_full),   0);
    checkOutput("rst_haz",   int'(bus.disp_hazard), 0);
    checkOutput("rst_cnt",   int'(bus.oitf_cnt),    0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("first_tag", int'(bus.disp_tag), 0);
    checkOutput("first_rdy", int'(bus.disp_rdy), 1);

    applyStimulus(1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("raw_cnt", int'(bus.oitf_cnt),    1);
    checkOutput("raw_haz", int'(bus.disp_hazard), 1);
    checkOutput("raw_rdy", int'(bus.disp_rdy),    0);

    applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 1, 0);
    @(negedge clk);
`ifdef OITF_CMT_BYPASS_EN
    checkOutput("cmt_cycle_haz", int'(bus.disp_hazard), 0);
`else
    checkOutput("cmt_cycle_haz", int'(bus.disp_hazard), 1);
`endif

    applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post_cmt_haz",   int'(bus.disp_hazard), 0);
    checkOutput("post_cmt_cnt",   int'(bus.oitf_cnt),    0);
    checkOutput("post_cmt_empty", int'(bus.oitf_empty),  1);

    for (int r = 1; r <= 4; r++) begin
      applyStimulus(1, 1, 1, r, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("fill_tag", int'(bus.disp_tag), r % DEPTH);
    end

    applyStimulus(1, 1, 1, 6, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_flag",     int'(bus.oitf_full), 1);
    checkOutput("full_cnt",      int'(bus.oitf_cnt),  4);
    checkOutput("full_long_rdy", int'(bus.disp_rdy),  0);

    applyStimulus(1, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_short_rdy", int'(bus.disp_rdy), 1);

    applyStimulus(1, 1, 1, 8, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
`ifdef OITF_CMT_BYPASS_EN
    checkOutput("bypass_rdy", int'(bus.disp_rdy), 1);
`else
    checkOutput("bypass_rdy", int'(bus.disp_rdy), 0);
`endif

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef OITF_CMT_BYPASS_EN
    checkOutput("bypass_cnt", int'(bus.oitf_cnt), 4);
`else
    checkOutput("bypass_cnt", int'(bus.oitf_cnt), 3);
`endif

    @(posedge clk);
    #1 rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      if (q.size() > 0 && ($urandom % 4) != 0)
        ct = q[$urandom_range(q.size() - 1, 0)].tag;
      else
        ct = int'($urandom % DEPTH);
      applyStimulus(int'($urandom % 2), int'($urandom % 2), int'($urandom % 2), int'($urandom % 8),
                    int'($urandom % 2), int'($urandom % 8), int'($urandom % 2), int'($urandom % 8),
                    int'(($urandom % 3) == 0), ct);
      rst_n = (($urandom % 400) != 0);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
